// File: rtl/booth_wallace_final_cpa_if.sv
// Valid/ready bundle between the Wallace tree, the final carry-propagate adder and its consumer.
// The adder takes the slave side; the driving environment takes the master side.
interface booth_wallace_final_cpa_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_row;
    logic [WIDTH-1:0] carry_row;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] product;

    modport master (
        output in_valid, sum_row, carry_row, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, sum_row, carry_row, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_wallace_final_cpa.sv
// Two-stage carry-propagate adder that resolves the Wallace tree's sum/carry rows into the product.
// Stage 1 adds the low SPLIT bits; stage 2 adds the high bits plus the stage-1 carry.
module booth_wallace_final_cpa #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 16
) (
    input logic                      sys_clk,
    input logic                      sys_rst,
    booth_wallace_final_cpa_if.slave bus
);
    localparam int unsigned HW = WIDTH - SPLIT;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             c_q, c_d;
    logic [HW-1:0]    hs_q, hs_d;
    logic [HW-1:0]    hc_q, hc_d;
    logic [WIDTH-1:0] prod_q, prod_d;

    logic             load1;
    logic             load2;
    logic             in_ready;
    logic [SPLIT:0]   lo_sum;
    logic [HW-1:0]    hi_sum;

    always_comb begin
        load2    = v1_q & (~v2_q | bus.out_ready);
        in_ready = ~sys_rst & (~v1_q | load2);
        load1    = bus.in_valid & in_ready;

        lo_sum = {1'b0, bus.sum_row[SPLIT-1:0]} + {1'b0, bus.carry_row[SPLIT-1:0]};
        // Carry out of the top bit is dropped: products wrap modulo 2^WIDTH.
        hi_sum = hs_q + hc_q + HW'(c_q);

        v1_d   = v1_q;
        v2_d   = v2_q;
        lo_d   = lo_q;
        c_d    = c_q;
        hs_d   = hs_q;
        hc_d   = hc_q;
        prod_d = prod_q;

        if (load1) begin
            lo_d = lo_sum[SPLIT-1:0];
            c_d  = lo_sum[SPLIT];
            hs_d = bus.sum_row[WIDTH-1:SPLIT];
            hc_d = bus.carry_row[WIDTH-1:SPLIT];
            v1_d = 1'b1;
        end else if (load2) begin
            v1_d = 1'b0;
        end

        if (load2) begin
            prod_d = {hi_sum, lo_q};
            v2_d   = 1'b1;
        end else if (bus.out_ready) begin
            v2_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            lo_q   <= '0;
            c_q    <= 1'b0;
            hs_q   <= '0;
            hc_q   <= '0;
            prod_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            lo_q   <= lo_d;
            c_q    <= c_d;
            hs_q   <= hs_d;
            hc_q   <= hc_d;
            prod_q <= prod_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v2_q;
    assign bus.product   = prod_q;
endmodule

// File: tb/tb_booth_wallace_final_cpa.sv
// Directed and randomized bench for booth_wallace_final_cpa; expected products come from
// a queue of (sum_row + carry_row) values pushed on every accepted input.
module tb_booth_wallace_final_cpa;
    localparam int unsigned W = 32;

    logic sys_clk = 1'b0;
    logic sys_rst;

    booth_wallace_final_cpa_if #(.WIDTH(W)) bus ();

    booth_wallace_final_cpa #(
        .WIDTH(W),
        .SPLIT(16)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic         consumed;
    logic [W-1:0] last_out;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, score the handshakes
    // that the next rising edge will act on.
    task automatic cycle(input logic iv, input logic [W-1:0] s, input logic [W-1:0] c,
                         input logic ordy);
        @(negedge sys_clk);
        bus.in_valid  = iv;
        bus.sum_row   = s;
        bus.carry_row = c;
        bus.out_ready = ordy;
        #1;
        consumed = 1'b0;
        if (bus.out_valid === 1'b1 && ordy) begin
            consumed = 1'b1;
            last_out = bus.product;
            chk("out_has_pending", W'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("sb_product", bus.product, exp_q.pop_front());
        end
        if (iv && bus.in_ready === 1'b1) exp_q.push_back(s + c);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, $urandom, $urandom, ordy);
    endtask

    // Single item through an empty pipeline with out_ready high.
    task automatic send_one(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                            input logic [W-1:0] expv);
        cycle(1'b1, s, c, 1'b1);
        chk({tag, "_accept"}, W'(bus.in_ready), 1);
        idle(1'b1);
        chk({tag, "_valid_n1"}, W'(bus.out_valid), 0);
        idle(1'b1);
        chk({tag, "_valid_n2"}, W'(bus.out_valid), 1);
        chk({tag, "_product"}, bus.product, expv);
        idle(1'b1);
        chk({tag, "_valid_after"}, W'(bus.out_valid), 0);
    endtask

    logic [W-1:0] st_s [4] = '{32'h1, 32'h10, 32'hFFFF, 32'h12345678};
    logic [W-1:0] st_c [4] = '{32'h2, 32'h20, 32'hFFFF, 32'h11111111};
    logic [W-1:0] st_e [4] = '{32'h3, 32'h30, 32'h0001FFFE, 32'h23456789};
    logic [W-1:0] bp_s [5] = '{32'h0000FFFF, 32'h80000000, 32'h12340000, 32'hFFFFFFFF, 32'h7FFF8000};
    logic [W-1:0] bp_c [5] = '{32'h00000001, 32'h80000000, 32'h0000ABCD, 32'hFFFFFFFF, 32'h00008000};
    logic [W-1:0] bp_e [5] = '{32'h00010000, 32'h00000000, 32'h1234ABCD, 32'hFFFFFFFE, 32'h80000000};

    initial begin
        int sent;
        int n_got;
        int first_i;
        int last_i;

        sys_rst       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sum_row   = '0;
        bus.carry_row = '0;
        bus.out_ready = 1'b0;
        consumed      = 1'b0;
        last_out      = '0;

        // Reset state
        #12;
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_product", bus.product, 0);
        chk("rst_in_ready", W'(bus.in_ready), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(bus.in_ready), 1);

        // Carry across the split and wrap-around cases
        send_one("carry_split", 32'h0000FFFF, 32'h00000001, 32'h00010000);
        send_one("wrap_zero", 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        send_one("wrap_neg15", 32'hFFFFFFF0, 32'h00000001, 32'hFFFFFFF1);

        // Streaming: four back-to-back items, one product per cycle
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1'b1, st_s[i], st_c[i], 1'b1);
            else       idle(1'b1);
            if (i < 4) chk("stream_in_ready", W'(bus.in_ready), 1);
            if (i >= 2) begin
                chk("stream_valid", W'(bus.out_valid), 1);
                chk("stream_product", bus.product, st_e[i-2]);
            end
        end
        idle(1'b1);
        chk("stream_drained", W'(bus.out_valid), 0);

        // Backpressure: out_ready low for the three cycles after the first product
        sent = 0; n_got = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 24 && n_got < 5; i++) begin
            if (sent < 5) cycle(1'b1, bp_s[sent], bp_c[sent], !(i >= 2 && i <= 4));
            else          idle(1'b1);
            if (sent < 5 && bus.in_ready === 1'b1) sent++;
            if (i >= 2 && i <= 4) begin
                chk("stall_valid", W'(bus.out_valid), 1);
                chk("stall_product", bus.product, bp_e[0]);
                chk("stall_in_ready", W'(bus.in_ready), 0);
            end
            if (consumed) begin
                chk("bp_order", last_out, bp_e[n_got]);
                if (first_i < 0) first_i = i;
                last_i = i;
                n_got++;
            end
        end
        chk("bp_count", W'(n_got), 5);
        chk("bp_no_gaps", W'(last_i - first_i), 4);
        idle(1'b1);

        // Reset while both stages hold data
        cycle(1'b1, 32'h11110000, 32'h00002222, 1'b0);
        cycle(1'b1, 32'h33330000, 32'h00004444, 1'b0);
        idle(1'b0);
        chk("pre_rst_full_valid", W'(bus.out_valid), 1);
        chk("pre_rst_full_in_ready", W'(bus.in_ready), 0);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("midrst_out_valid", W'(bus.out_valid), 0);
        chk("midrst_product", bus.product, 0);
        chk("midrst_in_ready", W'(bus.in_ready), 0);
        exp_q.delete();
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("no_stale_out", W'(bus.out_valid), 0);
        end
        send_one("after_rst", 32'hCAFE8000, 32'h0001_8000, 32'hCB000000);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] rs;
            logic [W-1:0] rc;
            rs = $urandom;
            rc = $urandom;
            if ($urandom_range(0, 7) == 0) rs[15:0] = 16'hFFFF;
            cycle($urandom_range(0, 3) != 0, rs, rc, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("final_drain_empty", W'(exp_q.size()), 0);
        chk("final_out_valid", W'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
